// File: rtl/iq_gain_scaler_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : drfm_scaler_pkg
//  Purpose  : Shared widths, gain/rounding constants and saturation limits
//             for the DRFM I/Q/sum amplitude scaler.
//  Revision : 1.0  initial release
// ============================================================================
package drfm_scaler_pkg;

  localparam int DEF_N_CH      = 3;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_GAIN_W    = 16;
  localparam int DEF_GAIN_FRAC = 15;

  // Gain value that represents exactly 1.0 in a Q-format with `frac` fraction bits
  function automatic longint unity_gain(input int frac);
    return longint'(1) <<< frac;
  endfunction

  // Half an LSB of the output, added before the shift for round-half-up
  function automatic longint round_bias(input int frac);
    return longint'(1) <<< (frac - 1);
  endfunction

  function automatic longint sat_max(input int dw);
    return (longint'(1) <<< (dw - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int dw);
    return -(longint'(1) <<< (dw - 1));
  endfunction

  localparam logic [DEF_GAIN_W-1:0] UNITY_GAIN = DEF_GAIN_W'(unity_gain(DEF_GAIN_FRAC));
  localparam longint                ROUND_BIAS = round_bias(DEF_GAIN_FRAC);

endpackage
`default_nettype wire

// File: rtl/iq_gain_scaler_if.sv
`default_nettype none
// ============================================================================
//  Module   : iq_gain_scaler_if
//  Purpose  : Streaming sample bus, gain control and status of the scaler.
//             master = upstream/control side, slave = scaler.
//  Revision : 1.0  initial release
// ============================================================================
interface iq_gain_scaler_if #(
  parameter int N_CH   = 3,
  parameter int DATA_W = 32,
  parameter int GAIN_W = 16
) ();

  logic                     in_valid;
  logic                     in_ready;
  logic [N_CH*DATA_W-1:0]   in_data;
  logic [N_CH*GAIN_W-1:0]   gain_in;
  logic                     gain_load;
  logic                     bypass;
  logic                     sat_clear;
  logic                     out_valid;
  logic                     out_ready;
  logic [N_CH*DATA_W-1:0]   out_data;
  logic [N_CH-1:0]          sat_flag;

  modport master (
    output in_valid, in_data, gain_in, gain_load, bypass, sat_clear, out_ready,
    input  in_ready, out_valid, out_data, sat_flag
  );

  modport slave (
    input  in_valid, in_data, gain_in, gain_load, bypass, sat_clear, out_ready,
    output in_ready, out_valid, out_data, sat_flag
  );

endinterface
`default_nettype wire

// File: rtl/iq_gain_scaler_lane.sv
`default_nettype none
// ============================================================================
//  Module   : scaler_lane
//  Purpose  : One channel datapath: S1 signed x unsigned multiply, S2 round
//             half-up, shift by the gain binary point and saturate.
//  Revision : 1.0  initial release
// ============================================================================
module scaler_lane
  import drfm_scaler_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int GAIN_W    = DEF_GAIN_W,
  parameter int GAIN_FRAC = DEF_GAIN_FRAC
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              s1_load,
  input  logic              s2_load,
  input  logic [DATA_W-1:0] data_in,
  input  logic [GAIN_W-1:0] gain,
  output logic [DATA_W-1:0] data_out,
  output logic              sat
);

  // One guard bit so the zero-extended gain stays positive as a signed operand
  localparam int P = DATA_W + GAIN_W + 1;

  localparam logic signed [P-1:0] c_bias = P'(round_bias(GAIN_FRAC));
  localparam logic signed [P-1:0] c_max  = P'(sat_max(DATA_W));
  localparam logic signed [P-1:0] c_min  = P'(sat_min(DATA_W));

  logic signed [P-1:0]  w_data_ext;
  logic signed [P-1:0]  w_gain_ext;
  logic signed [P-1:0]  prod_d, prod_q;
  logic signed [P-1:0]  w_rounded;
  logic signed [P-1:0]  w_shifted;
  logic [DATA_W-1:0]    w_result;
  logic [DATA_W-1:0]    out_d, out_q;

  // S1: full-precision product, captured only on an input transfer
  always_comb begin
    w_data_ext = {{(P-DATA_W){data_in[DATA_W-1]}}, data_in};
    w_gain_ext = {{(P-GAIN_W){1'b0}}, gain};
    prod_d     = s1_load ? (w_data_ext * w_gain_ext) : prod_q;
  end

  // S2: round, drop fraction bits and clamp to the sample range
  always_comb begin
    w_rounded = prod_q + c_bias;
    w_shifted = w_rounded >>> GAIN_FRAC;
    sat       = 1'b0;
    w_result  = w_shifted[DATA_W-1:0];
    if (w_shifted > c_max) begin
      sat      = 1'b1;
      w_result = c_max[DATA_W-1:0];
    end else if (w_shifted < c_min) begin
      sat      = 1'b1;
      w_result = c_min[DATA_W-1:0];
    end
    out_d = s2_load ? w_result : out_q;
  end

  // Pipeline registers, cleared on reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prod_q <= '0;
      out_q  <= '0;
    end else begin
      prod_q <= prod_d;
      out_q  <= out_d;
    end
  end

  assign data_out = out_q;

endmodule
`default_nettype wire

// File: rtl/iq_gain_scaler.sv
`default_nettype none
// ============================================================================
//  Module   : iq_gain_scaler
//  Purpose  : Multi-channel Q-format gain scaler with valid/ready handshake,
//             glitch-free gain loading and sticky saturation flags.
//  Revision : 1.0  initial release
// ============================================================================
module iq_gain_scaler
  import drfm_scaler_pkg::*;
#(
  parameter int N_CH      = DEF_N_CH,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int GAIN_W    = DEF_GAIN_W,
  parameter int GAIN_FRAC = DEF_GAIN_FRAC
) (
  input  logic             M100CLK,
  input  logic             reset_n,
  iq_gain_scaler_if.slave  bus
);

  localparam logic [GAIN_W-1:0] c_unity = GAIN_W'(unity_gain(GAIN_FRAC));

  logic                    en;
  logic                    s1_load;
  logic                    s2_load;
  logic                    s1_valid_d, s1_valid_q;
  logic                    out_valid_d, out_valid_q;
  logic [N_CH*GAIN_W-1:0]  gain_d, gain_q;
  logic [N_CH*GAIN_W-1:0]  w_sel_gain;
  logic [N_CH-1:0]         sat_d, sat_q;
  logic [N_CH-1:0]         w_lane_sat;
  logic [N_CH*DATA_W-1:0]  w_lane_out;

  // Both stages advance together whenever the output slot is free or draining
  assign en = !out_valid_q || bus.out_ready;

  // Next-state for valid bits, active gains and sticky flags
  always_comb begin
    s1_load     = en && bus.in_valid;
    s2_load     = en && s1_valid_q;
    s1_valid_d  = en ? bus.in_valid : s1_valid_q;
    out_valid_d = en ? s1_valid_q   : out_valid_q;
    // A sample accepted on a load edge still sees the old gain_q
    gain_d      = bus.gain_load ? bus.gain_in : gain_q;
    w_sel_gain  = bus.bypass ? {N_CH{c_unity}} : gain_q;
    // A set on the same edge as a clear takes priority
    sat_d       = bus.sat_clear ? '0 : sat_q;
    if (s2_load) begin
      sat_d = sat_d | w_lane_sat;
    end
  end

  // Control state shared by all lanes
  always_ff @(posedge M100CLK) begin
    if (!reset_n) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      gain_q      <= {N_CH{c_unity}};
      sat_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      gain_q      <= gain_d;
      sat_q       <= sat_d;
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_lane
    scaler_lane #(
      .DATA_W    (DATA_W),
      .GAIN_W    (GAIN_W),
      .GAIN_FRAC (GAIN_FRAC)
    ) u_lane (
      .clk      (M100CLK),
      .reset_n  (reset_n),
      .s1_load  (s1_load),
      .s2_load  (s2_load),
      .data_in  (bus.in_data[k*DATA_W +: DATA_W]),
      .gain     (w_sel_gain[k*GAIN_W +: GAIN_W]),
      .data_out (w_lane_out[k*DATA_W +: DATA_W]),
      .sat      (w_lane_sat[k])
    );
  end

  assign bus.in_ready  = en;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = w_lane_out;
  assign bus.sat_flag  = sat_q;

endmodule
`default_nettype wire

// File: doc/iq_gain_scaler.md
# iq_gain_scaler

Parametrised multi-channel amplitude scaler for the DRFM I/Q/sum sample path. Multiplies each signed channel sample by an unsigned fixed-point gain with an explicit binary point, then rounds and saturates back to sample width. Sits between the correlator/sum stage and the DAC formatter. Extends the fixed three-channel scaler with:
- a true Q-format gain (unity representable exactly);
- a valid/ready handshake with backpressure;
- glitch-free gain update and sticky saturation flags.

## Interface
- `N_CH`, 3, number of channels (I, Q, sum in the default build)
- `DATA_W`, 32, signed sample width in and out
- `GAIN_W`, 16, unsigned gain width
- `GAIN_FRAC`, 15, gain fraction bits; unity = 1<<GAIN_FRAC (0x8000 default)

Ports:
- `M100CLK` in 1: single clock, all logic rising-edge
- `reset_n` in 1: synchronous, active-low reset
- `in_valid` in 1: input sample set valid
- `in_ready` out 1: block can accept input this cycle
- `in_data` in N_CH*DATA_W: channel k at bits [k*DATA_W +: DATA_W], two's complement
- `gain_in` in N_CH*GAIN_W: per-channel gain, same packing
- `gain_load` in 1: one-cycle pulse, captures `gain_in` into the active gain registers
- `bypass` in 1: level, forces unity gain for samples accepted while high
- `sat_clear` in 1: clears all sticky saturation flags
- `out_valid` out 1: output sample set valid
- `out_ready` in 1: downstream accepts output
- `out_data` out N_CH*DATA_W: scaled samples, same packing
- `sat_flag` out N_CH: sticky per-channel saturation indicator

## Operation
- **Transfers.** An input transfer occurs when `in_valid && in_ready`; an output transfer when `out_valid && out_ready`.
- **Pipeline.** Two stages, S1 and S2, with a common advance enable `en = !out_valid || out_ready`. `in_ready = en`.
- **S1 (on input transfer).** Registers `in_data` and the selected gain, and computes the product. Width is `DATA_W+GAIN_W+1`: data is signed, gain is zero-extended to signed.
- **Gain selection.** The selected gain is the active gain, or unity if `bypass` is high.
- **S2 (round and saturate).** Add 2^(GAIN_FRAC-1) (round half toward +inf), then arithmetic shift right by `GAIN_FRAC`. Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- **Saturation flag.** When clamping occurs on a lane, set `sat_flag[k]` on the S2 load cycle.
- **Valid bits.** S1 and S2 each carry a valid bit. On `en`, S1 loads `in_valid` and S2 loads S1's contents.
- **Gain update.** Active gains update on the edge where `gain_load` is high. A sample accepted in that same cycle uses the old gain; the next accepted sample uses the new gain. Gains never change mid-sample.
- **`sat_clear`.** Clears flags at the edge. If a saturation event occurs in the same cycle, the set wins.
- **Reset (`reset_n` low at an edge).** Both valid bits → 0, `out_data` → 0, `sat_flag` → 0, active gains → unity. Applies mid-stream too: in-flight samples are discarded, never emitted.
- **Lane independence.** Saturation on one lane does not affect other lanes.

## Timing
- Latency is 2 cycles from input transfer to `out_valid`, with `out_ready` held high.
- Sustained throughput is one sample set per cycle while `out_ready` is high.
- `in_ready` is combinational from `out_valid` and `out_ready` only, with no path from `in_valid`. `out_valid` and `out_data` are registered.
- **Backpressure.** When `out_ready` is low with `out_valid` high, both stages hold, `in_ready` drops in the same cycle, and `out_data` stays stable until transferred.
- **No loss or duplication.** Up to 2 sample sets are held in flight. No sample is dropped or duplicated, and order is preserved.
- **During reset.** `in_ready` reads 1, since `out_valid` is 0. Inputs presented while `reset_n` is low are ignored.
- **Gain loads under backpressure.** `gain_load` is honoured during stalls; it affects only samples accepted afterwards.

## Structure
- **Package `drfm_scaler_pkg`:**
  - default widths;
  - `UNITY_GAIN` constant;
  - `ROUND_BIAS` constant;
  - saturation min/max constant functions of `DATA_W`.
- **Sub-module `scaler_lane`:** one channel's S1 multiply and S2 round/saturate datapath, with a sat output. Instantiated N_CH times via generate.
- **Top level:** handshake, valid bits, gain registers and sticky flags live in the top level, shared across lanes.

## Test plan
Defaults used: DATA_W=32, GAIN_W=16, GAIN_FRAC=15.
- **Unity gain.** Gain 0x8000 on all lanes, in_data {1000, -1000, 0}, `out_ready`=1 → `out_valid` 2 cycles later with {1000, -1000, 0}; `sat_flag`=0.
- **Rounding.** Gain 0x4000, in {-3, 3, 1} → out {-1, 2, 1}, confirming round-half-up.
- **Saturation and sticky flags.**
  - Gain 0xFFFF, in {0x7FFFFFFF, 0x80000000, 5} → out {0x7FFFFFFF, 0x80000000, 10}, `sat_flag`=3'b011.
  - Flags remain set after further clean samples; `sat_clear` → 0.
- **Backpressure.** Stream 4 samples, `out_ready` low for 5 cycles after the first `out_valid` → `in_ready` low throughout the stall. All 4 samples emerge in order, each exactly once, with `out_data` stable during the stall.
- **Gain change.** `gain_load` with gain 0x4000 in the same cycle as accepting sample A=100 (old gain 0x8000), then B=100 → outputs A=100, B=50. `bypass` high for sample C=100 → 100.
- **Reset mid-stream.** Assert `reset_n` low for 1 cycle with both stages full → next cycle `out_valid`=0, `sat_flag`=0. The in-flight samples never appear, and subsequent samples use unity gain.
